// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered ALU among NUM_REQ requesters.
// Optional macro ALU_ARB_ILLEGAL_CHECK_EN: opcodes above 3 bypass the ALU and return rsp_err.
module alu_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned DATA_WIDTH   = 30,
    parameter int unsigned OPCODE_WIDTH = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ*(OPCODE_WIDTH+1)-1:0] req_opcode,
    input  logic [NUM_REQ*(DATA_WIDTH+1)-1:0]   req_op1,
    input  logic [NUM_REQ*(DATA_WIDTH+1)-1:0]   req_op2,
    output logic                                rsp_valid,
    input  logic                                rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]          rsp_id,
    output logic [DATA_WIDTH:0]                 rsp_result,
    output logic                                rsp_carry,
    output logic                                rsp_zero,
    output logic                                rsp_err,
    output logic [OPCODE_WIDTH:0]               alu_opcode,
    output logic [DATA_WIDTH:0]                 alu_op1,
    output logic [DATA_WIDTH:0]                 alu_op2,
    input  logic [DATA_WIDTH:0]                 alu_result,
    input  logic                                alu_carry,
    input  logic                                alu_zero
);

    localparam int unsigned DW = DATA_WIDTH + 1;
    localparam int unsigned OW = OPCODE_WIDTH + 1;
    localparam int unsigned IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t        state;
    state_t        next_state;

    logic [IW-1:0] last_grant;
    logic [IW-1:0] grant;
    logic [IW-1:0] cand;
    logic          grant_found;
    logic          accept;
    logic          sel_illegal;

    logic [OW-1:0] opc_arr [NUM_REQ];
    logic [DW-1:0] op1_arr [NUM_REQ];
    logic [DW-1:0] op2_arr [NUM_REQ];
    logic [OW-1:0] sel_opcode;
    logic [DW-1:0] sel_op1;
    logic [DW-1:0] sel_op2;

    // Unflatten the per-requester payload buses
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
        assign opc_arr[g] = req_opcode[g*OW +: OW];
        assign op1_arr[g] = req_op1[g*DW +: DW];
        assign op2_arr[g] = req_op2[g*DW +: DW];
    end

    // Cyclic search starting just after the most recently served requester
    always_comb begin
        grant       = last_grant;
        grant_found = 1'b0;
        cand        = '0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IW'((32'(last_grant) + i) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant       = cand;
                grant_found = 1'b1;
            end
        end
    end

    assign sel_opcode = opc_arr[grant];
    assign sel_op1    = op1_arr[grant];
    assign sel_op2    = op2_arr[grant];

`ifdef ALU_ARB_ILLEGAL_CHECK_EN
    assign sel_illegal = (32'(sel_opcode) > 32'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_err <= 1'b0;
        end else if (accept) begin
            rsp_err <= sel_illegal;
        end
    end
`else
    assign sel_illegal = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state plus the combinational accept, which only exists in IDLE
    always_comb begin
        next_state = state;
        req_ready  = '0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    req_ready[grant] = 1'b1;
                    accept           = 1'b1;
                    next_state       = sel_illegal ? RESP : ISSUE;
                end
            end
            ISSUE:   next_state = CAPTURE;
            CAPTURE: next_state = RESP;
            RESP: begin
                if (rsp_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // ALU drive registers double as the request latch; rsp_* hold through RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= IW'(NUM_REQ - 1);
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            alu_opcode <= '0;
            alu_op1    <= '0;
            alu_op2    <= '0;
        end else begin
            rsp_valid <= (next_state == RESP);
            if (accept) begin
                last_grant <= grant;
                rsp_id     <= grant;
                if (sel_illegal) begin
                    rsp_result <= '0;
                    rsp_carry  <= 1'b0;
                    rsp_zero   <= 1'b0;
                end else begin
                    alu_opcode <= sel_opcode;
                    alu_op1    <= sel_op1;
                    alu_op2    <= sel_op2;
                end
            end
            if (state == CAPTURE) begin
                rsp_result <= alu_result;
                rsp_carry  <= alu_carry;
                rsp_zero   <= alu_zero;
            end
        end
    end

endmodule
